// File: rtl/axis_sample_gen.sv
// AXI-Stream ramp source: one packet of base + i*step samples per accepted start.
// Define AXIS_SAMPLE_GEN_SUM_EN to add the gen_sum running-total output.
module axis_sample_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  gen_start,
  input  logic [LEN_WIDTH-1:0]  gen_len,
  input  logic [DATA_WIDTH-1:0] gen_base,
  input  logic [DATA_WIDTH-1:0] gen_step,
  output logic                  gen_busy,
  output logic                  gen_done,
`ifdef AXIS_SAMPLE_GEN_SUM_EN
  output logic [DATA_WIDTH-1:0] gen_sum,
`endif
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LEN_WIDTH-1:0]  idxNext;
  logic [LEN_WIDTH-1:0]  lenLast;
  logic                  beatXfer;

  assign idxNext  = idx_q + LEN_WIDTH'(1);
  assign lenLast  = len_q - LEN_WIDTH'(1);
  assign beatXfer = tvalid_q && m_axis_tready;

  // DONE is the last busy cycle; the done pulse is registered on leaving it.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    step_d   = step_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gen_start) begin
          len_d  = gen_len;
          step_d = gen_step;
          idx_d  = '0;
          busy_d = 1'b1;
          if (gen_len != '0) begin
            state_d  = SEND;
            tvalid_d = 1'b1;
            tdata_d  = gen_base;
            tlast_d  = (gen_len == LEN_WIDTH'(1));
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (beatXfer) begin
          if (tlast_q) begin
            state_d  = DONE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
          end else begin
            tdata_d = tdata_q + step_q;
            idx_d   = idxNext;
            tlast_d = (idxNext == lenLast);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      step_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      step_q   <= step_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

`ifdef AXIS_SAMPLE_GEN_SUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  // Running total of transferred beats, restarted by every accepted start.
  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && gen_start) begin
      sum_d = '0;
    end else if (state_q == SEND && beatXfer) begin
      sum_d = sum_q + tdata_q;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign gen_sum = sum_q;
`endif

  assign gen_busy      = busy_q;
  assign gen_done      = done_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;

endmodule
